// File: rtl/ej32_div_seq.sv
// ej32_div_seq: sequenced radix-2 signed divider (idiv/irem) with a busy/done handshake
module ej32_div_seq #(
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           op,
  input  logic [DSZ-1:0] x,
  input  logic [DSZ-1:0] y,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic           dz,
  output logic [DSZ-1:0] r
);
  localparam int CW = $clog2(DSZ);
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  state_t st;
  logic op_q, sign_q, sign_r;
  logic [DSZ-1:0] x_q, y_q, quo, my, ax, ay, q_fix, r_fix;
  logic [DSZ:0] rem, rem_sh;
  logic [CW-1:0] cnt;
  logic ge;
  always_comb begin
    ax = x_q[DSZ-1] ? -x_q : x_q;
    ay = y_q[DSZ-1] ? -y_q : y_q;
    rem_sh = {rem[DSZ-1:0], quo[DSZ-1]};
    ge = rem_sh >= {1'b0, my};
    q_fix = sign_q ? -quo : quo;
    r_fix = sign_r ? -rem[DSZ-1:0] : rem[DSZ-1:0];
  end
  // The quotient register starts as |x| and has quotient bits shifted in as dividend bits shift out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      dz <= 1'b0;
      r <= '0;
      op_q <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      quo <= '0;
      my <= '0;
      rem <= '0;
      cnt <= '0;
    end else if (abort) begin
      st <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE, DONE: begin
          st <= start ? PREP : IDLE;
          if (start) begin
            op_q <= op;
            x_q <= x;
            y_q <= y;
            dz <= 1'b0;
            busy <= 1'b1;
          end
        end
        PREP: begin
          sign_q <= x_q[DSZ-1] ^ y_q[DSZ-1];
          sign_r <= x_q[DSZ-1];
          quo <= ax;
          my <= ay;
          rem <= '0;
          cnt <= CW'(DSZ - 1);
          st <= (y_q == '0) ? DONE : CALC;
          if (y_q == '0) begin
            dz <= 1'b1;
            r <= '0;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        CALC: begin
          rem <= ge ? rem_sh - {1'b0, my} : rem_sh;
          quo <= {quo[DSZ-2:0], ge};
          cnt <= cnt - 1'b1;
          st <= (cnt == '0) ? FIX : CALC;
        end
        FIX: begin
          r <= op_q ? r_fix : q_fix;
          done <= 1'b1;
          busy <= 1'b0;
          st <= DONE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ej32_div_seq.sv
// tb_ej32_div_seq: scoreboard bench for ej32_div_seq against a plain signed-arithmetic model
module tb_ej32_div_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, op = 1'b0, abort = 1'b0;
  logic [31:0] x = '0, y = '0;
  logic busy, done, dz;
  logic [31:0] r;
  int cyc = 0, cmp = 0, err = 0, bc = 0;
  typedef struct {logic [31:0] r; logic dz; int t0;} exp_t;
  exp_t q[$];

  ej32_div_seq #(.DSZ(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .x(x), .y(y),
    .abort(abort), .busy(busy), .done(done), .dz(dz), .r(r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    cmp++;
    if (act !== expv) begin
      err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic o);
    exp_t e;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    e.t0 = 0;
    e.dz = (b == 0);
    e.r = (b == 0) ? 32'd0 : o ? 32'(sa % sb) : 32'(sa / sb);
    return e;
  endfunction

  function automatic logic [31:0] rnd_val();
    int k = $urandom_range(0, 8);
    return k == 0 ? 32'd0 : k == 1 ? 32'd1 : k == 2 ? 32'hFFFF_FFFF :
           k == 3 ? 32'h8000_0000 : k == 4 ? 32'h7FFF_FFFF : k == 5 ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
  endfunction

  // Monitor: checks each done pulse against the oldest outstanding expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) bc = 0;
    else if (done) begin
      if (q.size() == 0) begin
        cmp++;
        err++;
        $display("FAIL unexpected_done: got r=%h, expected no done", r);
      end else begin
        e = q.pop_front();
        chk("result", r, e.r);
        chk("dz", 32'(dz), 32'(e.dz));
        chk("latency", 32'(cyc - e.t0), e.dz ? 32'd2 : 32'd35);
        chk("busy_cycles", 32'(bc), e.dz ? 32'd1 : 32'd34);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      bc = 0;
    end else if (busy) bc++;
    else bc = 0;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic o);
    exp_t e;
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("wait_not_busy", 32'(busy), 32'd0);
    e = model(a, b, o);
    e.t0 = cyc;
    q.push_back(e);
    start = 1'b1;
    x = a;
    y = b;
    op = o;
    @(negedge clk);
    start = 1'b0;
    x = $urandom;
    y = $urandom;
    op = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    logic [31:0] dx[10] = '{32'd7, 32'd7, -32'd7, -32'd7, 32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd12345, -32'd5};
    logic [31:0] dy[10] = '{32'd2, 32'd2, 32'd2, 32'd2, -32'd2, -32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [9:0] dop = 10'b10_1010_1010;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_dz", 32'(dz), 32'd0);
    chk("reset_r", r, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // Directed sign/overflow/zero cases, issued back-to-back from each DONE cycle.
    for (int i = 0; i < 10; i++) issue(dx[i], dy[i], dop[i]);
    drain();
    // A start during busy must be ignored.
    issue(32'd100, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1; x = 32'd1; y = 32'd1; op = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    // Abort mid-CALC (with a competing start) leaves the previous result.
    issue(32'd1000, 32'd3, 1'b1);
    drain();
    issue(32'd50, 32'd6, 1'b0);
    repeat (10) @(negedge clk);
    abort = 1'b1; start = 1'b1; x = 32'd9; y = 32'd2; op = 1'b0;
    q.delete(q.size() - 1);
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_keeps_r", r, 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    // Asynchronous reset mid-CALC.
    issue(32'd123456, -32'd3, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    chk("rst_r", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(-32'd100, 32'd7, 1'b1);
    drain();
    for (int i = 0; i < 1000; i++) issue(rnd_val(), rnd_val(), 1'($urandom));
    drain();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
